// File: rtl/trakball_pkg.sv
// Shared constants for the trackball receiver: trakball_i bit positions,
// the default counter width and the snapshot FSM state type.
package trakball_pkg;

  localparam int unsigned CNT_W_DEF = 4;

  // Odd bit of each duplicated pair in trakball_i; the even bit sits one below.
  localparam int unsigned X_DIR  = 7;
  localparam int unsigned X_STEP = 5;
  localparam int unsigned Y_DIR  = 3;
  localparam int unsigned Y_STEP = 1;

  typedef enum logic {
    StIdle,
    StResp
  } snap_state_e;

endpackage

// File: rtl/trak_axis_dec.sv
// One trackball axis: input synchroniser, optional stability filter (TRAK_RX_FILTER_EN),
// step edge detect, wrapping up/down counter and step pulse.
module trak_axis_dec
  import trakball_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYC    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic [1:0]       step_pair,
  input  logic [1:0]       dir_pair,
  input  logic             up,
  output logic             dir,
  output logic             step,
  output logic [CNT_W-1:0] count,
  output logic             pair_mis
);

  if (SYNC_STAGES < 2 || FILT_CYC < 1) begin : g_param_err
    $error("trak_axis_dec: SYNC_STAGES must be >= 2 and FILT_CYC >= 1");
  end

  // Bit order inside each stage: {dir_odd, dir_even, step_odd, step_even}.
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]                  sync_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], dir_pair, step_pair};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign pair_mis = (sync_out[3] ^ sync_out[2]) | (sync_out[1] ^ sync_out[0]);

  logic step_s;
  logic dir_s;

`ifdef TRAK_RX_FILTER_EN
  localparam int unsigned FW = $clog2(FILT_CYC + 1);

  logic [1:0]         raw;
  logic [1:0]         filt_q;
  logic [1:0][FW-1:0] fcnt_q;

  assign raw = {sync_out[3], sync_out[1]};

  // A bit is accepted once it has differed from the filtered value for FILT_CYC cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= '0;
      fcnt_q <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (raw[b] == filt_q[b]) begin
          fcnt_q[b] <= '0;
        end else if (fcnt_q[b] == FW'(FILT_CYC - 1)) begin
          filt_q[b] <= raw[b];
          fcnt_q[b] <= '0;
        end else begin
          fcnt_q[b] <= fcnt_q[b] + FW'(1);
        end
      end
    end
  end

  assign step_s = filt_q[0];
  assign dir_s  = filt_q[1];
`else
  assign step_s = sync_out[1];
  assign dir_s  = sync_out[3];
`endif

  logic             step_prev_q;
  logic             step_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             step_det;

  assign step_det = step_s ^ step_prev_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (step_det) begin
      count_d = up ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_prev_q <= 1'b0;
      step_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      step_prev_q <= step_s;
      step_q      <= step_det;
      count_q     <= count_d;
    end
  end

  assign dir   = dir_s;
  assign step  = step_q;
  assign count = count_q;

endmodule

// File: rtl/trakball_quad_rx.sv
// Trackball direction+step receiver: two axis decoders, cocktail flip, counter clear,
// snapshot read port and sticky pair-mismatch flag. Filter option: TRAK_RX_FILTER_EN.
module trakball_quad_rx
  import trakball_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYC    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       trakball_i,
  input  logic             flip,
  input  logic             clr,
  input  logic             rd_req,
  input  logic             rd_sel,
  output logic             rd_valid,
  output logic [CNT_W:0]   rd_data,
  output logic [CNT_W-1:0] x_count,
  output logic [CNT_W-1:0] y_count,
  output logic             x_step,
  output logic             y_step,
  output logic             pair_err
);

  logic x_dir;
  logic y_dir;
  logic x_up;
  logic y_up;
  logic x_mis;
  logic y_mis;

  assign x_up = x_dir ^ flip;
  assign y_up = y_dir ^ flip;

  trak_axis_dec #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_CYC   (FILT_CYC)
  ) u_x_dec (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (clr),
    .step_pair(trakball_i[X_STEP -: 2]),
    .dir_pair (trakball_i[X_DIR -: 2]),
    .up       (x_up),
    .dir      (x_dir),
    .step     (x_step),
    .count    (x_count),
    .pair_mis (x_mis)
  );

  trak_axis_dec #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_CYC   (FILT_CYC)
  ) u_y_dec (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (clr),
    .step_pair(trakball_i[Y_STEP -: 2]),
    .dir_pair (trakball_i[Y_DIR -: 2]),
    .up       (y_up),
    .dir      (y_dir),
    .step     (y_step),
    .count    (y_count),
    .pair_mis (y_mis)
  );

  // Snapshot port: the live counter register is sampled, so a same-cycle step is not included.
  snap_state_e    state_q;
  snap_state_e    state_d;
  logic [CNT_W:0] rd_data_q;
  logic [CNT_W:0] rd_data_d;

  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    case (state_q)
      StIdle:  state_d = rd_req ? StResp : StIdle;
      StResp:  state_d = rd_req ? StResp : StIdle;
      default: state_d = StIdle;
    endcase
    if (rd_req) begin
      rd_data_d = rd_sel ? {y_up, y_count} : {x_up, x_count};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_valid = (state_q == StResp);
  assign rd_data  = rd_data_q;

  // Mismatch must persist two cycles before it is flagged.
  logic mis_q;
  logic err_q;
  logic any_mis;

  assign any_mis = x_mis | y_mis;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      mis_q <= any_mis;
      if (clr) begin
        err_q <= 1'b0;
      end else if (any_mis && mis_q) begin
        err_q <= 1'b1;
      end
    end
  end

  assign pair_err = err_q;

endmodule

// File: tb/tb_trakball_quad_rx.sv
// Directed bench for trakball_quad_rx; snapshot responses are checked by a queue scoreboard.
module tb_trakball_quad_rx;

  localparam int unsigned CNT_W = 4;
`ifdef TRAK_RX_FILTER_EN
  localparam int LAT        = 7;
  localparam int GLITCH_EXP = 0;
`else
  localparam int LAT        = 3;
  localparam int GLITCH_EXP = 2;
`endif

  logic             clk     = 1'b0;
  logic             reset_n = 1'b1;
  logic [7:0]       trakball_i;
  logic             flip    = 1'b0;
  logic             clr     = 1'b0;
  logic             rd_req  = 1'b0;
  logic             rd_sel  = 1'b0;
  logic             rd_valid;
  logic [CNT_W:0]   rd_data;
  logic [CNT_W-1:0] x_count;
  logic [CNT_W-1:0] y_count;
  logic             x_step;
  logic             y_step;
  logic             pair_err;

  logic xs = 1'b0, xd = 1'b0, ys = 1'b0, yd = 1'b0, bad6 = 1'b0;
  assign trakball_i = {xd, xd ^ bad6, xs, xs, yd, yd, ys, ys};

  trakball_quad_rx #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2),
    .FILT_CYC   (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .trakball_i(trakball_i),
    .flip      (flip),
    .clr       (clr),
    .rd_req    (rd_req),
    .rd_sel    (rd_sel),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .x_count   (x_count),
    .y_count   (y_count),
    .x_step    (x_step),
    .y_step    (y_step),
    .pair_err  (pair_err)
  );

  always #5 clk = ~clk;

  int             n_tests  = 0;
  int             n_fail   = 0;
  int             x_pulses = 0;
  int             y_pulses = 0;
  logic [CNT_W:0] sb[$];
  logic [CNT_W:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_steps(input bit do_x, input bit do_y, input int n);
    for (int i = 0; i < n; i++) begin
      if (do_x) xs = ~xs;
      if (do_y) ys = ~ys;
      tick(LAT + 1);
    end
  endtask

  // Monitor: counts step pulses and scores every snapshot response.
  always @(negedge clk) begin
    if (x_step === 1'b1) x_pulses++;
    if (y_step === 1'b1) y_pulses++;
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_valid_unexpected: got valid with data %0d, expected no valid", rd_data);
      end else begin
        mon_exp = sb.pop_front();
        chk("rd_data", 32'(rd_data), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset_n = 1'b0;
    tick(2);
    chk("reset_x_count", 32'(x_count), 0);
    chk("reset_y_count", 32'(y_count), 0);
    chk("reset_rd_valid", 32'(rd_valid), 0);
    chk("reset_rd_data", 32'(rd_data), 0);
    chk("reset_pair_err", 32'(pair_err), 0);
    chk("reset_x_step", 32'(x_step), 0);
    reset_n = 1'b1;
    tick(2);

    // Three X toggles, dir up: pulse exactly LAT cycles after each toggle.
    xd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      xs = ~xs;
      tick(LAT - 1);
      chk("x_step_early", 32'(x_step), 0);
      tick(1);
      chk("x_step_latency", 32'(x_step), 1);
      tick(2);
    end
    chk("x_count_3", 32'(x_count), 3);
    chk("x_pulses_3", 32'(x_pulses), 3);
    chk("y_count_idle", 32'(y_count), 0);

    // Wrap down and back up.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("x_count_clr", 32'(x_count), 0);
    xd = 1'b0;
    pulse_steps(1'b1, 1'b0, 1);
    chk("x_wrap_down", 32'(x_count), 15);
    xd = 1'b1;
    pulse_steps(1'b1, 1'b0, 17);
    chk("x_wrap_up", 32'(x_count), 0);

    // Flip inverts both axes; simultaneous X and Y steps are independent.
    flip = 1'b1;
    yd   = 1'b1;
    xs   = ~xs;
    ys   = ~ys;
    tick(LAT);
    chk("xy_same_x_step", 32'(x_step), 1);
    chk("xy_same_y_step", 32'(y_step), 1);
    tick(1);
    pulse_steps(1'b0, 1'b1, 1);
    chk("flip_y_count", 32'(y_count), 14);
    chk("flip_x_count", 32'(x_count), 15);
    flip = 1'b0;

    // Snapshot: X=5 then same-cycle increment, back-to-back Y read.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    xd  = 1'b1;
    pulse_steps(1'b1, 1'b0, 5);
    yd = 1'b1;
    pulse_steps(1'b0, 1'b1, 2);
    yd = 1'b0;
    tick(LAT + 2);
    chk("snap_x_pre", 32'(x_count), 5);
    xs = ~xs;
    tick(LAT - 1);
    rd_req = 1'b1;
    rd_sel = 1'b0;
    sb.push_back({1'b1, 4'd5});
    tick(1);
    chk("snap_x_after_inc", 32'(x_count), 6);
    rd_sel = 1'b1;
    sb.push_back({1'b0, 4'd2});
    tick(1);
    chk("snap_b2b_valid", 32'(rd_valid), 1);
    rd_req = 1'b0;
    tick(2);
    chk("snap_sb_drained", 32'(sb.size()), 0);
    chk("snap_rd_valid_low", 32'(rd_valid), 0);
    chk("snap_rd_data_hold", 32'(rd_data), 2);

    // clr beats a same-cycle step; the pulse still fires.
    xs = ~xs;
    tick(LAT - 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_step_pulse", 32'(x_step), 1);
    chk("clr_step_x_count", 32'(x_count), 0);
    chk("clr_y_count", 32'(y_count), 0);

    // Pair mismatch: one cycle ignored, two cycles sticky until clr.
    bad6 = 1'b1;
    tick(1);
    bad6 = 1'b0;
    tick(6);
    chk("pair_err_1cyc", 32'(pair_err), 0);
    bad6 = 1'b1;
    tick(2);
    bad6 = 1'b0;
    tick(4);
    chk("pair_err_set", 32'(pair_err), 1);
    tick(5);
    chk("pair_err_sticky", 32'(pair_err), 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("pair_err_clr", 32'(pair_err), 0);

    // Two-cycle glitch on stepX: filtered away, or two raw steps without the filter.
    xs = ~xs;
    tick(2);
    xs = ~xs;
    tick(LAT + 4);
    chk("glitch_x_count", 32'(x_count), 32'(GLITCH_EXP));

    // Reset during RESP: response is dropped and nothing follows release.
    rd_req = 1'b1;
    rd_sel = 1'b0;
    tick(1);
    chk("resp_before_reset", 32'(rd_valid), 1);
    #1 reset_n = 1'b0;
    rd_req = 1'b0;
    xs = 1'b0;
    xd = 1'b0;
    ys = 1'b0;
    yd = 1'b0;
    #1;
    chk("reset_mid_rd_valid", 32'(rd_valid), 0);
    chk("reset_mid_rd_data", 32'(rd_data), 0);
    chk("reset_mid_x_count", 32'(x_count), 0);
    tick(2);
    reset_n = 1'b1;
    tick(LAT + 3);
    chk("post_reset_rd_valid", 32'(rd_valid), 0);
    chk("post_reset_x_count", 32'(x_count), 0);
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trakball_quad_rx.md
Name: trakball_quad_rx

Overview:
- Receiver/decoder for the trackball direction+step signalling that the top level synthesises from PS/2 mouse deltas.
- Per axis: synchronises the step and direction lines, counts each step toggle into a wrapping up/down counter, and offers a snapshot read port to the game core.
- Sits between the trackball source (mouse encoder or real encoder via USER_IN) and the Centipede core's trackball input register.

Parameters:
- CNT_W, 4, width of each axis position counter.
- SYNC_STAGES, 2, flip-flop synchroniser depth on all input bits (minimum 2).
- FILT_CYC, 4, cycles an input must be stable before acceptance (used only with the optional feature).

Ports:
- clk  in  1  system clock (12 MHz domain).
- reset_n  in  1  asynchronous, active-low reset.
- trakball_i  in  8  {dirX,dirX,stepX,stepX,dirY,dirY,stepY,stepY}; duplicated pairs carry the same signal.
- flip  in  1  cocktail flip; inverts both direction senses.
- clr  in  1  synchronous clear of both counters.
- rd_req  in  1  single-cycle snapshot request.
- rd_sel  in  1  axis select for the snapshot: 0 = X, 1 = Y.
- rd_valid  out  1  one-cycle pulse, exactly 1 cycle after rd_req.
- rd_data  out  CNT_W+1  {dir, count} of the selected axis at the rd_req cycle.
- x_count  out  CNT_W  live X counter.
- y_count  out  CNT_W  live Y counter.
- x_step  out  1  one-cycle pulse per accepted X step.
- y_step  out  1  one-cycle pulse per accepted Y step.
- pair_err  out  1  sticky; set when the two duplicate bits of any pair disagree after synchronisation for 2 consecutive cycles.

Behaviour:
- Reset: all synchroniser stages, edge registers and counters go to 0, and every output is 0.
- Synchronisation: every input bit passes through SYNC_STAGES flops. Decoding uses the odd bits of each pair (7, 5, 3, 1); the even bits feed only the pair_err check.
- Step detection: any change (rising or falling) of the synchronised step bit versus its previous value is one step.
  - The step pulse asserts on the cycle after the changed value leaves the synchroniser.
  - Total input-to-pulse latency is SYNC_STAGES+1 cycles.
- Direction: the effective direction is the synchronised dir XOR flip, sampled in the same cycle the step is detected. 1 increments the counter, 0 decrements it.
- Counter arithmetic: modulo 2^CNT_W, so 15+1 = 0 and 0-1 = 15. There is no saturation.
- clr: takes priority over a simultaneous step, and the counter goes to 0. The step pulse output still fires.
- Snapshot FSM, states IDLE -> RESP -> IDLE:
  - rd_req in IDLE latches {effective dir of the selected axis, counter value before any same-cycle step} into rd_data.
  - rd_valid pulses in the next cycle (RESP).
  - rd_req asserted during RESP is accepted: back-to-back requests give back-to-back valids.
  - rd_data holds its value until the next request.
- Reset asserted mid-operation: the counters and FSM clear asynchronously, and no pending rd_valid is emitted after reset release.
- pair_err: sticky until reset_n or clr.
- X and Y steps in the same cycle are fully independent.

Optional Feature:
- Macro: TRAK_RX_FILTER_EN.
- Defined: each synchronised step and dir bit goes through a stability filter, implemented as a per-bit counter.
  - The filtered value updates only after the raw bit has held a new value for FILT_CYC consecutive cycles.
  - Glitches shorter than FILT_CYC are discarded.
  - Latency becomes SYNC_STAGES+FILT_CYC+1 cycles.
- Undefined: no filter logic is present and latency is SYNC_STAGES+1 cycles.

Decomposition:
- Package trakball_pkg holds:
  - localparams for the bit positions within trakball_i (X_DIR=7, X_STEP=5, Y_DIR=3, Y_STEP=1);
  - the snapshot FSM state enum {IDLE, RESP};
  - the default CNT_W.
- One sub-module, trak_axis_dec, instantiated twice (X and Y), contains: synchroniser, optional filter, edge detect, up/down counter and step pulse.
- The top level holds flip, clr fan-out, the snapshot FSM and pair_err.

Test Plan:
- Reset release, then 3 X step toggles with dirX=1, flip=0 -> x_count = 3, three x_step pulses, each 3 cycles after its toggle; y_count stays 0.
- x_count = 0, one step with dirX=0 -> x_count = 15 (wrap). Then 17 steps with dirX=1 -> x_count = 0.
- flip=1, dirY=1, 2 Y steps -> y_count = 14; a simultaneous X step in the same cycle counts independently.
- x_count = 5, rd_req with rd_sel=0 in the same cycle as an X increment -> next cycle rd_valid=1, rd_data = {1, 5}; x_count = 6. A back-to-back rd_req on rd_sel=1 gives the Y value one cycle later.
- clr in the same cycle as a step -> counter = 0 and step pulse seen. Force bit 6 != bit 7 for 2 cycles -> pair_err=1, held until clr.
- With TRAK_RX_FILTER_EN, a 2-cycle glitch on stepX -> no count. A 4-cycle-stable toggle -> count after 7 cycles. Reset_n pulse mid-RESP -> no rd_valid.
